// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word width and the word type used by
// every datapath and memory-side block.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_arbiter_types_pkg.sv
// Types private to the memory arbiter: the ownership state of the RAM.
package mem_arbiter_types_pkg;

  // IDLE is the arbitration cycle; IGRANT/DGRANT mean that requester owns the RAM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's signals, with one view per attached party:
// the arbiter itself, the instruction side, the data side and the RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  iwait;

  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;

  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport icache (
    output iREN, iaddr,
    input  iload, iwait
  );

  modport dcache (
    output dREN, dWEN, daddr, dstore,
    input  dload, dwait
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data memory.
// Data wins by default; after STARVE_MAX consecutive data grants with a
// fetch waiting, the fetch is forced through. Every grant returns to IDLE,
// so there is always one arbitration cycle between two RAM accesses.
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arbiter_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  iwait,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dwait,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready
);

  localparam int unsigned CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic             dreq;
  logic             starved;

  assign dreq    = dREN | dWEN;
  assign starved = (starveCnt_q == CNT_W'(STARVE_MAX));

  // Read data is shared; only the owner's wait flag says whether it is valid
  assign iload = ramload;
  assign dload = ramload;

  // Ownership state and starvation count, cleared by the synchronous reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // Pick the next owner in IDLE; leave a grant on completion or when the owner drops its request
  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    unique case (state_q)
      IDLE: begin
        if (iREN && starved) begin
          state_d     = IGRANT;
          starveCnt_d = '0;
        end else if (dreq) begin
          state_d = DGRANT;
          if (iREN) begin
            starveCnt_d = starved ? starveCnt_q : starveCnt_q + CNT_W'(1);
          end else begin
            starveCnt_d = '0;
          end
        end else if (iREN) begin
          state_d     = IGRANT;
          starveCnt_d = '0;
        end
      end
      IGRANT: begin
        if (!iREN || ramready) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (!dreq || ramready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Steer the owner's request onto the RAM and release its wait when the RAM is ready
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state_q)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~(iREN & ramready);
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~(dreq & ramready);
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch requester and the data-memory requester of the pipelined datapath.
- Each cycle, at most one requester owns the RAM. The winner's address, enables and store data are driven to the RAM. The RAM result is returned to the winner, and the winner's wait flag is released on completion.
- Data requests have priority. A bounded starvation counter guarantees that instruction fetch makes forward progress.

Parameters:
- STARVE_MAX, 3: number of consecutive data grants allowed while an instruction request is pending. After that, the instruction requester is forced to win.
- WORD_W, 32: address and data width, taken from the shared CPU types package.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data
- iwait  out  1  1 = instruction access not complete this cycle
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write data
- dload  out  32  data read data
- dwait  out  1  1 = data access not complete this cycle
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramready  in  1  RAM completes the presented access this cycle

Behaviour:
- Reset: a rising CLK edge with nRST=0 sets state=IDLE and starve_cnt=0. While in IDLE:
  - ramREN, ramWEN = 0; ramaddr, ramstore = 0.
  - iwait, dwait = 1.
  - iload, dload = ramload (pass-through, always).
- States are IDLE, IGRANT and DGRANT. The state and starve_cnt are registered; all outputs are combinational from the state and inputs.
- dreq = dREN | dWEN.
- Transitions from IDLE:
  - If iREN and starve_cnt == STARVE_MAX, go to IGRANT.
  - Else if dreq, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- IGRANT outputs: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0, iwait = ~(iREN & ramready), dwait=1.
- DGRANT outputs: ramWEN=dWEN, ramREN=dREN & ~dWEN, ramaddr=daddr, ramstore=dstore, dwait = ~(dreq & ramready), iwait=1.
  - If dREN and dWEN are both high, the access is a write. dload is don't-care in that case.
- Completion: in a grant state with the owner's request high and ramready=1, the owner's wait goes low that same cycle and the next state is IDLE.
- Abort: if the owner drops its request while in a grant state, the next state is IDLE, no ack is given, and RAM enables are 0 in that cycle.
- Minimum latency: 2 cycles from request assertion to wait=0 (one IDLE arbitration cycle, then one grant cycle with ramready=1). ramready held low stretches the grant state indefinitely.
- Back-to-back: every grant returns through IDLE, so there is one arbitration cycle between grants with no RAM access.
- Starvation counter update, on leaving IDLE:
  - Into DGRANT while iREN=1: starve_cnt increments, saturating at STARVE_MAX.
  - Into IGRANT: starve_cnt resets to 0.
  - Into DGRANT while iREN=0: starve_cnt resets to 0.
- ramready is ignored in IDLE.
- Reset asserted mid-grant: the next edge forces IDLE. The in-flight access is dropped with no ack.
- Address and data must be held stable by requesters while their wait=1. This is a requester obligation; the arbiter does not latch them.

Decomposition:
- Add an arb_state_t enum (IDLE, IGRANT, DGRANT) to a new mem_arbiter_types_pkg.
- Add a mem_arbiter_if interface with modports arb, icache, dcache and ram, matching the other block interfaces in the codebase.
- word_t comes from cpu_types_pkg.
- Single module, no sub-modules. The starvation counter is small enough to stay inline.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with iREN=1 → ramREN=0, ramWEN=0, iwait=1, dwait=1. Release reset → IGRANT on the next cycle, ramaddr=iaddr.
- Single fetch: iREN=1, iaddr=0x40, ramready=1, ramload=0x8C010004 → cycle 1 IGRANT, iwait=0, iload=0x8C010004. Cycle 2 IDLE.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x100) → DGRANT first, dwait low when ramready is high; iwait stays 1. Then IDLE, then IGRANT.
- Starvation: iREN=1 held while dREN is re-raised after every ack, ramready=1 → exactly 3 DGRANTs, then IGRANT, and starve_cnt returns to 0.
- Write with wait states: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready low for 3 cycles → ramWEN=1 with stable address and data for 4 grant cycles; dwait falls only in the 4th.
- Abort and mid-grant reset: drop dREN during DGRANT with ramready=0 → IDLE next cycle, no dwait=0 pulse. Separately, assert nRST=0 in IGRANT → IDLE, iwait=1, starve_cnt=0.
